// File: rtl/parity_arbiter_ctrl_pkg.sv
// Shared types, constants and the parity helper for the parity arbiter slice.
package parity_pkg;

  localparam logic SRC_GEN = 1'b0;
  localparam logic SRC_CHK = 1'b1;

  localparam int PARITY_DATA_W = 8;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [PARITY_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/parity_arbiter_ctrl_if.sv
// Request/response bundle between the TX/RX datapaths, the CSR side and the arbiter.
interface parity_arbiter_ctrl_if #(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
);

  logic              gen_valid;
  logic              gen_ready;
  logic [DATA_W-1:0] gen_data;

  logic              chk_valid;
  logic              chk_ready;
  logic [DATA_W-1:0] chk_data;
  logic              chk_parity;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_src;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_parity;
  logic              rsp_error;

  logic [ERR_CNT_W-1:0] err_count;
  logic                 err_clr;

  modport master (
    output gen_valid, gen_data,
    output chk_valid, chk_data, chk_parity,
    output rsp_ready, err_clr,
    input  gen_ready, chk_ready,
    input  rsp_valid, rsp_src, rsp_data, rsp_parity, rsp_error,
    input  err_count
  );

  modport slave (
    input  gen_valid, gen_data,
    input  chk_valid, chk_data, chk_parity,
    input  rsp_ready, err_clr,
    output gen_ready, chk_ready,
    output rsp_valid, rsp_src, rsp_data, rsp_parity, rsp_error,
    output err_count
  );

endinterface

// File: rtl/parity_arbiter_ctrl_core.sv
// Combinational even-parity engine shared by the generator and checker paths.
module parity_core
  import parity_pkg::*;
#(
  parameter int DATA_W = PARITY_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  input  logic              rx_parity,
  output logic              parity,
  output logic              error
);

  // Parity of the word, and whether the received parity bit disagrees with it.
  always_comb begin
    parity = even_parity(data);
    error  = parity ^ rx_parity;
  end

endmodule

// File: rtl/parity_arbiter_ctrl.sv
// Round-robin arbiter sharing one parity core between generator and checker,
// with a single-entry response buffer and a saturating checker-error counter.
module parity_arbiter_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  parity_arbiter_ctrl_if.slave bus
);

  buf_state_t           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 rsp_src_q, rsp_src_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_parity_q, rsp_parity_d;
  logic                 rsp_error_q, rsp_error_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic              can_accept;
  logic              grant_valid;
  logic              grant_src;
  logic              accept;
  logic [DATA_W-1:0] core_data;
  logic              core_rx_parity;
  logic              core_parity;
  logic              core_error;

  // One core serves whichever source holds the grant.
  parity_core #(.DATA_W(DATA_W)) u_core (
    .data      (core_data),
    .rx_parity (core_rx_parity),
    .parity    (core_parity),
    .error     (core_error)
  );

  // Arbitration, core input mux, buffer next state and counter next value.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    rsp_src_d      = rsp_src_q;
    rsp_data_d     = rsp_data_q;
    rsp_parity_d   = rsp_parity_q;
    rsp_error_d    = rsp_error_q;
    err_count_d    = err_count_q;
    grant_valid    = 1'b0;
    grant_src      = SRC_GEN;

    can_accept = (state_q == BUF_EMPTY) | bus.rsp_ready;

    if (bus.gen_valid && bus.chk_valid) begin
      grant_valid = 1'b1;
      grant_src   = (last_grant_q == SRC_GEN) ? SRC_CHK : SRC_GEN;
    end else if (bus.gen_valid) begin
      grant_valid = 1'b1;
      grant_src   = SRC_GEN;
    end else if (bus.chk_valid) begin
      grant_valid = 1'b1;
      grant_src   = SRC_CHK;
    end

    accept = can_accept & grant_valid;

    core_data      = (grant_src == SRC_CHK) ? bus.chk_data : bus.gen_data;
    core_rx_parity = (grant_src == SRC_CHK) ? bus.chk_parity : 1'b0;

    unique case (state_q)
      BUF_EMPTY: if (accept) state_d = BUF_FULL;
      BUF_FULL: begin
        if (accept)             state_d = BUF_FULL;
        else if (bus.rsp_ready) state_d = BUF_EMPTY;
      end
      default: state_d = BUF_EMPTY;
    endcase

    if (accept) begin
      last_grant_d = grant_src;
      rsp_src_d    = grant_src;
      rsp_data_d   = core_data;
      rsp_parity_d = core_parity;
      rsp_error_d  = (grant_src == SRC_CHK) ? core_error : 1'b0;
    end

    if (bus.err_clr) begin
      err_count_d = '0;
    end else if (accept && (grant_src == SRC_CHK) && core_error &&
                 (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  // State and response registers; reset drops any held response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= BUF_EMPTY;
      last_grant_q <= SRC_CHK;
      rsp_src_q    <= SRC_GEN;
      rsp_data_q   <= '0;
      rsp_parity_q <= 1'b0;
      rsp_error_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_src_q    <= rsp_src_d;
      rsp_data_q   <= rsp_data_d;
      rsp_parity_q <= rsp_parity_d;
      rsp_error_q  <= rsp_error_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.gen_ready  = accept & (grant_src == SRC_GEN);
  assign bus.chk_ready  = accept & (grant_src == SRC_CHK);
  assign bus.rsp_valid  = (state_q == BUF_FULL);
  assign bus.rsp_src    = rsp_src_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_parity = rsp_parity_q;
  assign bus.rsp_error  = rsp_error_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_parity_arbiter_ctrl.sv
// Directed self-checking bench for parity_arbiter_ctrl.
module tb_parity_arbiter_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  parity_arbiter_ctrl_if #(.DATA_W(8), .ERR_CNT_W(8)) bus ();

  parity_arbiter_ctrl #(.DATA_W(8), .ERR_CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic gv, input logic [7:0] gd,
                               input logic cv, input logic [7:0] cd, input logic cp,
                               input logic rr, input logic ec);
    bus.gen_valid  = gv;
    bus.gen_data   = gd;
    bus.chk_valid  = cv;
    bus.chk_data   = cd;
    bus.chk_parity = cp;
    bus.rsp_ready  = rr;
    bus.err_clr    = ec;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRsp(input string tag, input logic v, input logic src,
                          input logic [7:0] d, input logic p, input logic e);
    checkOutput({tag, "_valid"},  32'(bus.rsp_valid),  32'(v));
    checkOutput({tag, "_src"},    32'(bus.rsp_src),    32'(src));
    checkOutput({tag, "_data"},   32'(bus.rsp_data),   32'(d));
    checkOutput({tag, "_parity"}, 32'(bus.rsp_parity), 32'(p));
    checkOutput({tag, "_error"},  32'(bus.rsp_error),  32'(e));
  endtask

  // Linear directed sequence of steps.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    stepClock();
    stepClock();
    $display("[TB] reset state");
    checkRsp("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("reset_errcnt", 32'(bus.err_count), 32'h0);

    rst_n = 1'b1;
    $display("[TB] generator only");
    applyStimulus(1'b1, 8'h7A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("gen7a_gen_ready", 32'(bus.gen_ready), 32'h1);
    checkOutput("gen7a_chk_ready", 32'(bus.chk_ready), 32'h0);
    stepClock();
    checkRsp("gen7a", 1'b1, 1'b0, 8'h7A, 1'b1, 1'b0);

    applyStimulus(1'b1, 8'h78, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("gen78_gen_ready", 32'(bus.gen_ready), 32'h1);
    stepClock();
    checkRsp("gen78", 1'b1, 1'b0, 8'h78, 1'b0, 1'b0);

    $display("[TB] checker good and bad");
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h07, 1'b1, 1'b1, 1'b0);
    checkOutput("chk07_chk_ready", 32'(bus.chk_ready), 32'h1);
    checkOutput("chk07_gen_ready", 32'(bus.gen_ready), 32'h0);
    stepClock();
    checkRsp("chk07", 1'b1, 1'b1, 8'h07, 1'b1, 1'b0);
    checkOutput("chk07_errcnt", 32'(bus.err_count), 32'h0);

    applyStimulus(1'b0, 8'h00, 1'b1, 8'hCC, 1'b1, 1'b1, 1'b0);
    stepClock();
    checkRsp("chkcc", 1'b1, 1'b1, 8'hCC, 1'b0, 1'b1);
    checkOutput("chkcc_errcnt", 32'(bus.err_count), 32'h1);

    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("idle_gen_ready", 32'(bus.gen_ready), 32'h0);
    checkOutput("idle_chk_ready", 32'(bus.chk_ready), 32'h0);
    stepClock();
    checkOutput("drain_valid", 32'(bus.rsp_valid), 32'h0);

    $display("[TB] tie alternation");
    applyStimulus(1'b1, 8'h01, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("tie%0d_gen_ready", i), 32'(bus.gen_ready), 32'((i % 2) == 0));
      checkOutput($sformatf("tie%0d_chk_ready", i), 32'(bus.chk_ready), 32'((i % 2) == 1));
      stepClock();
      checkOutput($sformatf("tie%0d_valid", i), 32'(bus.rsp_valid), 32'h1);
      checkOutput($sformatf("tie%0d_src", i), 32'(bus.rsp_src), 32'((i % 2) == 1));
    end

    $display("[TB] backpressure");
    applyStimulus(1'b1, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("bp%0d_gen_ready", i), 32'(bus.gen_ready), 32'h0);
      checkOutput($sformatf("bp%0d_chk_ready", i), 32'(bus.chk_ready), 32'h0);
      stepClock();
      checkRsp($sformatf("bp%0d", i), 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'h01, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
    checkOutput("bprel_gen_ready", 32'(bus.gen_ready), 32'h1);
    stepClock();
    checkRsp("bprel", 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);

    applyStimulus(1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
    checkOutput("pend_chk_ready", 32'(bus.chk_ready), 32'h1);
    stepClock();
    checkRsp("pend", 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);

    $display("[TB] counter saturation and clear");
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    stepClock();
    checkOutput("clr_errcnt", 32'(bus.err_count), 32'h0);

    applyStimulus(1'b0, 8'h00, 1'b1, 8'hCC, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 255; i++) stepClock();
    checkOutput("sat255_errcnt", 32'(bus.err_count), 32'hFF);
    stepClock();
    checkOutput("sat256_errcnt", 32'(bus.err_count), 32'hFF);

    applyStimulus(1'b0, 8'h00, 1'b1, 8'hCC, 1'b1, 1'b1, 1'b1);
    stepClock();
    checkOutput("clrwins_errcnt", 32'(bus.err_count), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hCC, 1'b1, 1'b1, 1'b0);
    stepClock();
    checkOutput("postclr_errcnt", 32'(bus.err_count), 32'h1);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    stepClock();
    checkOutput("midrst_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("midrst_errcnt", 32'(bus.err_count), 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h7A, 1'b1, 8'hCC, 1'b1, 1'b1, 1'b0);
    checkOutput("postrst_gen_ready", 32'(bus.gen_ready), 32'h1);
    checkOutput("postrst_chk_ready", 32'(bus.chk_ready), 32'h0);
    stepClock();
    checkRsp("postrst", 1'b1, 1'b0, 8'h7A, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
